instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential instruction fetch front end. Issues one word read at a time to
// instruction memory, captures the returned word together with its address,
// slices it into decode fields and presents it downstream with a valid/ready
// handshake. A redirect strobe retargets the fetch stream from any state; a
// read that is already outstanding when a redirect arrives is allowed to
// complete on the bus but its data is thrown away (squashed).
//
// Parameters
//   RESET_PC     fetch address loaded on reset
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   rst          asynchronous active-high reset
//   mem_req      instruction memory read request (high only in FETCH)
//   mem_addr     word-aligned read address, held stable while mem_req is high
//   mem_ack      read-data-valid strobe from memory
//   mem_rdata    instruction word, sampled only when mem_ack is high
//   redirect     branch/jump redirect strobe
//   redirect_pc  redirect target; bits [1:0] are ignored (forced to zero)
//   out_valid    an instruction is presented downstream
//   out_ready    downstream accepts the presented instruction
//   ir           presented instruction word
//   opcode       ir[31:26]
//   reg1         ir[25:21]
//   reg2         ir[20:16]
//   reg3         ir[15:11]
//   offset       ir[10:0]
//   pc_out       address the presented instruction was fetched from
//   fetch_count  number of instructions accepted downstream (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic [4:0]  reg3,
    output logic [10:0] offset,
    output logic [31:0] pc_out,
    output logic [31:0] fetch_count
);

    // FSM encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;           // next address to fetch (latest target)
    logic        squash;       // outstanding read belongs to a stale stream
    logic [31:0] squash_addr;  // address of that stale outstanding read

    logic [31:0] target;
    logic        handshake;
    logic        unused_redirect_lsbs;

    // Targets are word aligned; the low two bits of redirect_pc carry no
    // information for this fetch unit.
    assign target               = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign handshake = out_valid & out_ready;

    // mem_req is decoded straight from the state register so that an
    // asynchronous reset removes the request without waiting for a clock.
    assign mem_req = (state == FETCH);

    // While a squashed read is still outstanding the bus must keep showing
    // the address that read was issued with, even though pc already holds
    // the new target.
    assign mem_addr = squash ? squash_addr : pc;

    // -------------------------------------------------------------------------
    // Control: state, pc, squash tracking, handshake counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            squash_addr <= 32'h0000_0000;
            fetch_count <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    // Any memory acknowledge seen here is left over from
                    // before reset and is ignored.
                    state <= FETCH;
                    if (redirect) begin
                        pc <= target;
                    end
                end

                FETCH: begin
                    if (mem_ack) begin
                        squash <= 1'b0;
                        if (redirect) begin
                            // Data discarded, restart at the fresh target.
                            pc    <= target;
                            state <= FETCH;
                        end else if (squash) begin
                            // Stale data discarded; pc already holds the
                            // last redirect target.
                            state <= FETCH;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (redirect) begin
                        pc     <= target;
                        squash <= 1'b1;
                        // Remember only the address of the read actually on
                        // the bus; later redirects just overwrite pc.
                        if (!squash) begin
                            squash_addr <= pc;
                        end
                    end
                end

                HOLD: begin
                    if (handshake) begin
                        state       <= FETCH;
                        fetch_count <= fetch_count + 32'd1;
                        pc          <= redirect ? target : pc + 32'd4;
                    end else if (redirect) begin
                        // Held instruction is dropped without being counted.
                        state <= FETCH;
                        pc    <= target;
                    end
                end

                default: begin
                    state  <= IDLE;
                    squash <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register: instruction word, decode fields, pc_out, out_valid
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ir        <= 32'h0000_0000;
            opcode    <= 6'h00;
            reg1      <= 5'h00;
            reg2      <= 5'h00;
            reg3      <= 5'h00;
            offset    <= 11'h000;
            pc_out    <= 32'h0000_0000;
        end else begin
            if (state == FETCH && mem_ack && !redirect && !squash) begin
                // Fields are registered alongside ir so they change in the
                // same cycle and need no decode logic on the output path.
                out_valid <= 1'b1;
                ir        <= mem_rdata;
                opcode    <= mem_rdata[31:26];
                reg1      <= mem_rdata[25:21];
                reg2      <= mem_rdata[20:16];
                reg3      <= mem_rdata[15:11];
                offset    <= mem_rdata[10:0];
                pc_out    <= pc;
            end else if (state == HOLD && (handshake || redirect)) begin
                out_valid <= 1'b0;
            end else if (state != HOLD) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
